// File: rtl/uart_tx.sv
// UART transmitter: one byte per tx_start, LSB first, optional parity,
// one or two stop bits. Bit timing matches uart_rx for loopback.
module uart_tx #(
  parameter int CLK_PER_BIT = 20,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [15:0] CNT_MAX   = 16'(CLK_PER_BIT - 1);
  localparam logic        PAR_EN    = (PARITY_EN != 0);
  localparam logic        PAR_ODD   = (PARITY_ODD != 0);
  // Anything other than 2 stop bits falls back to 1.
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        stop_cnt, stop_cnt_nxt;
  logic [7:0]  shift_reg, shift_nxt;
  logic        par_bit, par_nxt;
  logic        tx_nxt, busy_nxt, done_nxt;
  logic        bit_end;

  assign bit_end = (clk_cnt == CNT_MAX);

  // State, datapath and registered outputs; async reset aborts any frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      stop_cnt  <= stop_cnt_nxt;
      shift_reg <= shift_nxt;
      par_bit   <= par_nxt;
      tx        <= tx_nxt;
      tx_busy   <= busy_nxt;
      tx_done   <= done_nxt;
    end
  end

  // Next-state and next-output logic; outputs change on bit boundaries only.
  always_comb begin
    state_nxt    = state;
    clk_cnt_nxt  = clk_cnt;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    shift_nxt    = shift_reg;
    par_nxt      = par_bit;
    tx_nxt       = tx;
    busy_nxt     = tx_busy;
    done_nxt     = tx_done;

    // Bit-time counter runs in every in-frame state and wraps at bit end.
    if (state inside {START, DATA, PARITY, STOP})
      clk_cnt_nxt = bit_end ? 16'd0 : clk_cnt + 16'd1;

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        if (tx_start) begin
          shift_nxt    = data_in;
          par_nxt      = (^data_in) ^ PAR_ODD;
          state_nxt    = START;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          clk_cnt_nxt  = '0;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          tx_nxt      = shift_reg[0];
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            stop_cnt_nxt = 1'b0;
            if (PAR_EN) begin
              state_nxt = PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            tx_nxt      = shift_reg[bit_cnt + 3'd1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt    = STOP;
          tx_nxt       = 1'b1;
          stop_cnt_nxt = 1'b0;
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          if (stop_cnt == STOP_LAST) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt   = IDLE;
        tx_nxt      = 1'b1;
        done_nxt    = 1'b0;
        clk_cnt_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, 8N1 by default, with optional parity and a selectable number of stop bits. It serialises one byte per tx_start request onto the tx line, LSB first. Its timing matches the team's uart_rx, so tx→rx loopback works when both use the same CLK_PER_BIT. It sits beside uart_rx behind the AXI-lite UART peripheral and is driven by register-write logic.

Parameters:
CLK_PER_BIT, 20, clk cycles per bit on the wire; legal range 2..65535 (16-bit counter); 5208 gives 9600 baud at 50 MHz
PARITY_EN, 0, 1 inserts a parity bit after D7
PARITY_ODD, 0, when PARITY_EN=1: 0 selects even parity, 1 selects odd parity
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
tx_start  input  1  transmit request; sampled only in IDLE
data_in  input  8  byte to send; captured on the accepting edge
tx  output  1  serial line; idles high
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: tx=1, tx_busy=0, tx_done=0, state=IDLE, counters and shift register cleared. Reset mid-frame aborts the frame immediately; tx returns high with no further edge needed.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: tx=1, tx_busy=0. On an edge with tx_start=1:
  - data_in → shift_reg
  - parity bit = XOR(data_in) XOR PARITY_ODD, latched
  - state → START, tx←0, tx_busy←1, clk_counter←0
- Bit timing: clk_counter counts 0..CLK_PER_BIT-1. Every bit, including each stop bit, holds tx for exactly CLK_PER_BIT cycles. The state advances on the edge where clk_counter==CLK_PER_BIT-1, and the counter then wraps to 0.
- START → DATA. tx←shift_reg[0], bit_counter←0.
- DATA: bit_counter increments at each bit end, and tx←shift_reg[bit_counter+1].
  - After bit 7 with PARITY_EN=1: go to PARITY, tx←parity.
  - After bit 7 with PARITY_EN=0: go to STOP, tx←1.
- PARITY → STOP after one bit time; tx←1.
- STOP: tx=1 for STOP_BITS×CLK_PER_BIT cycles, tracked by a stop counter. Then go to DONE, with tx_busy←0 and tx_done←1.
- DONE: lasts one cycle. tx_done=1, tx=1. Next state is IDLE, where tx_done←0.
- Frame length, from the accepting edge to the tx_done assertion edge: (1+8+PARITY_EN+STOP_BITS)×CLK_PER_BIT cycles.
- tx_start is ignored in START..DONE. It is not queued.
- data_in changes after the accepting edge have no effect on the frame in flight.
- If tx_start is held high continuously, a new frame is accepted on the first IDLE cycle. The minimum idle-high gap between frames is therefore 2 cycles beyond the stop bits (the DONE and IDLE cycles).
- tx_done and tx_busy are never high in the same cycle.
- Illegal STOP_BITS values are treated as 1.

Test Plan:
1. CLK_PER_BIT=20, send 0x55 → tx holds 0,1,0,1,0,1,0,1,0,1, 20 cycles each. tx_busy is high for 200 cycles, and tx_done pulses exactly 200 cycles after the accepting edge, for 1 cycle.
2. Loopback tx→uart_rx.rx, both CLK_PER_BIT=20. Send 0xA3, then 0x00, then 0xFF back-to-back with tx_start held → uart_rx reports data_out 0xA3, 0x00, 0xFF, with one rx_done each and no framing error.
3. PARITY_EN=1, PARITY_ODD=0, send 0x07 → parity bit=1 at bit slot 9, and the frame is 220 cycles. With PARITY_ODD=1 the parity bit=0.
4. STOP_BITS=2, send 0x80 → tx is high for 40 cycles after D7 (D7=1), and tx_done appears at cycle 220.
5. Pulse tx_start with 0x12, then pulse tx_start with 0x34 and change data_in at cycle 50 → only 0x12 is sent, with a single tx_done.
6. Assert reset at cycle 95 mid-DATA → tx=1 and tx_busy=0 within the same cycle, with no tx_done. A tx_start issued after release sends a clean frame.
